// File: rtl/frame_draw_scheduler.sv
// Single owner of the box drawer: each refresh period it clears the background once,
// then forwards every object's latest box in fixed index order.
module frame_draw_scheduler #(
    parameter int          NUM_OBJ            = 3,
    parameter logic [8:0]  SCREEN_WIDTH       = 9'd320,
    parameter logic [8:0]  SCREEN_HEIGHT      = 9'd240,
    parameter logic [2:0]  BG_COLOR           = 3'd0,
    parameter logic [31:0] REFRESH_RATE_COUNT = 32'd833332
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_OBJ-1:0]   obj_valid,
    output logic [NUM_OBJ-1:0]   obj_ready,
    input  logic [9*NUM_OBJ-1:0] obj_x,
    input  logic [9*NUM_OBJ-1:0] obj_y,
    input  logic [9*NUM_OBJ-1:0] obj_w,
    input  logic [9*NUM_OBJ-1:0] obj_h,
    input  logic [3*NUM_OBJ-1:0] obj_color,
    input  logic                 m_ready,
    output logic                 m_valid,
    output logic [8:0]           out_box_x,
    output logic [8:0]           out_box_y,
    output logic [8:0]           out_box_w,
    output logic [8:0]           out_box_h,
    output logic [2:0]           out_box_color,
    output logic                 frame_done
);

    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    typedef enum logic [1:0] {S_DRAW_BG, S_DRAW_OBJ, S_WAIT_REFRESH} state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        refresh_cnt;
    logic               armed;
    logic [8:0]         sh_x [NUM_OBJ];
    logic [8:0]         sh_y [NUM_OBJ];
    logic [8:0]         sh_w [NUM_OBJ];
    logic [8:0]         sh_h [NUM_OBJ];
    logic [2:0]         sh_color [NUM_OBJ];
    logic [NUM_OBJ-1:0] seen;
    logic               drawable;
    logic               slot_done;
    logic               entering_bg;

    // Zero-sized boxes are never forwarded: the drawer would never finish them.
    assign drawable    = seen[idx] && (sh_w[idx] != 9'd0) && (sh_h[idx] != 9'd0);
    assign slot_done   = (state == S_DRAW_OBJ) && (!drawable || m_ready);
    assign entering_bg = (next_state == S_DRAW_BG) && (state != S_DRAW_BG);

    always_ff @(posedge clock) begin
        if (!reset_n) state <= S_DRAW_BG;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_DRAW_BG:      if (armed && m_ready) next_state = S_DRAW_OBJ;
            S_DRAW_OBJ:     if (slot_done && idx == LAST_IDX) next_state = S_WAIT_REFRESH;
            S_WAIT_REFRESH: if (refresh_cnt == REFRESH_RATE_COUNT) next_state = S_DRAW_BG;
            default:        next_state = S_DRAW_BG;
        endcase
    end

    always_comb begin
        m_valid       = 1'b0;
        out_box_x     = 9'd0;
        out_box_y     = 9'd0;
        out_box_w     = 9'd1;
        out_box_h     = 9'd1;
        out_box_color = 3'd0;
        obj_ready     = '0;
        case (state)
            S_DRAW_BG: begin
                if (armed) begin
                    m_valid       = 1'b1;
                    out_box_w     = SCREEN_WIDTH;
                    out_box_h     = SCREEN_HEIGHT;
                    out_box_color = BG_COLOR;
                end
            end
            S_DRAW_OBJ: begin
                if (drawable) begin
                    m_valid       = 1'b1;
                    out_box_x     = sh_x[idx];
                    out_box_y     = sh_y[idx];
                    out_box_w     = sh_w[idx];
                    out_box_h     = sh_h[idx];
                    out_box_color = sh_color[idx];
                end
            end
            S_WAIT_REFRESH: obj_ready = '1;
            default: ;
        endcase
    end

    // armed keeps m_valid low for the first cycle after reset, so a reset mid-command drops it at once.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            armed       <= 1'b0;
            idx         <= '0;
            refresh_cnt <= 32'd0;
            frame_done  <= 1'b0;
        end else begin
            armed      <= 1'b1;
            frame_done <= slot_done && (idx == LAST_IDX);
            if (state == S_DRAW_BG)
                idx <= '0;
            else if (slot_done && idx != LAST_IDX)
                idx <= idx + IDX_W'(1);
            if (!armed || entering_bg)
                refresh_cnt <= 32'd0;
            else if (refresh_cnt != REFRESH_RATE_COUNT)
                refresh_cnt <= refresh_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (!reset_n) begin
                sh_x[i]     <= 9'd0;
                sh_y[i]     <= 9'd0;
                sh_w[i]     <= 9'd0;
                sh_h[i]     <= 9'd0;
                sh_color[i] <= 3'd0;
                seen[i]     <= 1'b0;
            end else if (obj_valid[i] && obj_ready[i]) begin
                sh_x[i]     <= obj_x[9*i +: 9];
                sh_y[i]     <= obj_y[9*i +: 9];
                sh_w[i]     <= obj_w[9*i +: 9];
                sh_h[i]     <= obj_h[9*i +: 9];
                sh_color[i] <= obj_color[3*i +: 3];
                seen[i]     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed bench for frame_draw_scheduler: 3 objects, 16x12 screen, refresh count 20.
module tb_frame_draw_scheduler;

    logic        clock;
    logic        reset_n;
    logic [2:0]  obj_valid;
    logic [2:0]  obj_ready;
    logic [26:0] obj_x, obj_y, obj_w, obj_h;
    logic [8:0]  obj_color;
    logic        m_ready;
    logic        m_valid;
    logic [8:0]  out_box_x, out_box_y, out_box_w, out_box_h;
    logic [2:0]  out_box_color;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    frame_draw_scheduler #(
        .NUM_OBJ(3), .SCREEN_WIDTH(9'd16), .SCREEN_HEIGHT(9'd12),
        .BG_COLOR(3'd0), .REFRESH_RATE_COUNT(32'd20)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .obj_valid(obj_valid), .obj_ready(obj_ready),
        .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h), .obj_color(obj_color),
        .m_ready(m_ready), .m_valid(m_valid),
        .out_box_x(out_box_x), .out_box_y(out_box_y), .out_box_w(out_box_w),
        .out_box_h(out_box_h), .out_box_color(out_box_color), .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic skip(input int n);
        repeat (n) cyc();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [8:0] x, input logic [8:0] y,
                             input logic [8:0] w, input logic [8:0] h, input logic [2:0] c);
        check(tag, {m_valid, out_box_x, out_box_y, out_box_w, out_box_h, out_box_color},
                   {1'b1, x, y, w, h, c});
    endtask

    task automatic check_idle(input string tag);
        check(tag, {m_valid, out_box_x, out_box_y, out_box_w, out_box_h, out_box_color},
                   {1'b0, 9'd0, 9'd0, 9'd1, 9'd1, 3'd0});
    endtask

    task automatic set_objs(input logic [2:0] v, input logic [26:0] x, input logic [26:0] y,
                            input logic [26:0] w, input logic [26:0] h, input logic [8:0] c);
        obj_valid = v;
        obj_x = x; obj_y = y; obj_w = w; obj_h = h; obj_color = c;
    endtask

    initial begin
        reset_n = 1'b0;
        m_ready = 1'b1;
        set_objs(3'b000, '0, '0, '0, '0, '0);

        // Reset held: nothing offered, nothing accepted.
        skip(3);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_obj_ready", obj_ready, 3'b000);
        reset_n = 1'b1;

        // Frame a: background only, three skipped slots.
        cyc();
        check_cmd("t1_bg", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        check("t1_bg_obj_ready", obj_ready, 3'b000);
        cyc(); check_idle("t1_skip0"); check("t1_fd_early", frame_done, 1'b0);
        cyc(); check_idle("t1_skip1");
        cyc(); check_idle("t1_skip2");
        cyc(); check("t1_frame_done", frame_done, 1'b1); check("t1_wait_ready", obj_ready, 3'b111);
        check_idle("t1_wait_idle");
        cyc(); check("t1_frame_done_pulse", frame_done, 1'b0);

        // Objects 0 and 2 offered while waiting (cycle a+6).
        cyc();
        set_objs(3'b101, {9'd8, 9'd0, 9'd2}, {9'd5, 9'd0, 9'd3}, {9'd2, 9'd0, 9'd1},
                 {9'd2, 9'd0, 9'd4}, {3'd7, 3'd0, 3'd1});
        cyc();
        obj_valid = 3'b000;
        skip(13);
        check_idle("t1_still_waiting");

        // Frame b: 21 cycles after frame a's background command.
        cyc(); check_cmd("t2_bg", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        cyc(); check_cmd("t2_obj0", 9'd2, 9'd3, 9'd1, 9'd4, 3'd1);
        cyc(); check_idle("t2_obj1_skip");
        cyc(); check_cmd("t2_obj2", 9'd8, 9'd5, 9'd2, 9'd2, 3'd7);
        cyc(); check("t2_frame_done", frame_done, 1'b1);

        // Frame c: drawer stalls five cycles on object 0 while objects try to update.
        skip(17); check_cmd("t3_bg", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        cyc(); check_cmd("t3_obj0_s0", 9'd2, 9'd3, 9'd1, 9'd4, 3'd1);
        check("t3_ready_s0", obj_ready, 3'b000);
        m_ready = 1'b0;
        set_objs(3'b111, {3{9'd100}}, {3{9'd101}}, {3{9'd7}}, {3{9'd7}}, {3{3'd5}});
        for (int i = 1; i < 5; i++) begin
            cyc();
            check_cmd($sformatf("t3_obj0_s%0d", i), 9'd2, 9'd3, 9'd1, 9'd4, 3'd1);
            check($sformatf("t3_ready_s%0d", i), obj_ready, 3'b000);
        end
        m_ready = 1'b1;
        obj_valid = 3'b000;
        cyc(); check_idle("t3_obj1_skip");
        cyc(); check_cmd("t3_obj2", 9'd8, 9'd5, 9'd2, 9'd2, 3'd7);
        cyc(); check("t3_frame_done", frame_done, 1'b1);

        // Object 1 arrives with zero width (cycle c+9).
        cyc();
        set_objs(3'b010, {9'd0, 9'd4, 9'd0}, {9'd0, 9'd4, 9'd0}, {9'd0, 9'd0, 9'd0},
                 {9'd0, 9'd3, 9'd0}, {3'd0, 3'd2, 3'd0});
        cyc();
        obj_valid = 3'b000;
        skip(11); check_cmd("t4_bg", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        cyc(); check_cmd("t4_obj0", 9'd2, 9'd3, 9'd1, 9'd4, 3'd1);
        cyc(); check_idle("t4_obj1_zero_w");
        cyc(); check_cmd("t4_obj2", 9'd8, 9'd5, 9'd2, 9'd2, 3'd7);
        cyc(); check("t4_frame_done", frame_done, 1'b1);

        // Width update lands on the same edge that starts the next frame.
        skip(16);
        check_idle("t4_last_wait"); check("t4_last_wait_ready", obj_ready, 3'b111);
        set_objs(3'b010, {9'd0, 9'd4, 9'd0}, {9'd0, 9'd4, 9'd0}, {9'd0, 9'd3, 9'd0},
                 {9'd0, 9'd3, 9'd0}, {3'd0, 3'd2, 3'd0});
        cyc(); check_cmd("t4b_bg", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        obj_valid = 3'b000;
        cyc(); check_cmd("t4b_obj0", 9'd2, 9'd3, 9'd1, 9'd4, 3'd1);
        cyc(); check_cmd("t4b_obj1", 9'd4, 9'd4, 9'd3, 9'd3, 3'd2);
        cyc(); check_cmd("t4b_obj2", 9'd8, 9'd5, 9'd2, 9'd2, 3'd7);
        cyc(); check("t4b_frame_done", frame_done, 1'b1);

        // Frame f: background stalled 30 cycles, so the wait afterwards lasts one cycle.
        skip(16);
        m_ready = 1'b0;
        cyc(); check_cmd("t5_bg_stall0", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        skip(29); check_cmd("t5_bg_stall29", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        m_ready = 1'b1;
        cyc(); check_cmd("t5_obj0", 9'd2, 9'd3, 9'd1, 9'd4, 3'd1);
        cyc(); check_cmd("t5_obj1", 9'd4, 9'd4, 9'd3, 9'd3, 3'd2);
        cyc(); check_cmd("t5_obj2", 9'd8, 9'd5, 9'd2, 9'd2, 3'd7);
        cyc(); check_idle("t5_wait"); check("t5_frame_done", frame_done, 1'b1);
        cyc(); check_cmd("t5_next_bg", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);

        // Frame g: reset pulse while object 1 is pending.
        cyc(); check_cmd("t6_obj0", 9'd2, 9'd3, 9'd1, 9'd4, 3'd1);
        cyc(); check_cmd("t6_obj1", 9'd4, 9'd4, 9'd3, 9'd3, 3'd2);
        m_ready = 1'b0;
        reset_n = 1'b0;
        cyc(); check("t6_valid_drop", m_valid, 1'b0); check("t6_ready_rst", obj_ready, 3'b000);
        check("t6_fd_rst", frame_done, 1'b0);
        reset_n = 1'b1;
        m_ready = 1'b1;
        cyc(); check_cmd("t6_bg", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        cyc(); check_idle("t6_skip0");
        cyc(); check_idle("t6_skip1");
        cyc(); check_idle("t6_skip2");
        cyc(); check("t6_frame_done", frame_done, 1'b1);
        skip(16); check_idle("t6_wait_end");
        cyc(); check_cmd("t6_next_bg", 9'd0, 9'd0, 9'd16, 9'd12, 3'd0);
        cyc(); check_idle("t6_next_skip0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
